addr_reg_xy_decode: RTL and testbench
=====================================

Name: addr_reg_xy_decode

Overview:
Parametrised memory address register and X/Y/sector core-driver decoder. Successor to the fixed 9-bit LVDC address X/Y decode.
- Field loads from the transfer register are gated by the transfer-enable flag.
- Adds sequential increment, extended-mode forcing and a sequenced drive window with overrun/abort detection.
- Sits between the transfer register and the core-memory X/Y selection-switch drivers.

Parameters:
XW, 3, X-field width; AX one-hot width is 2**XW
YW, 3, Y-field width; AY one-hot width is 2**YW
SW, 3, sector/syllable field width; AS one-hot width is 2**SW
DRIVE_CYC, 2, cycles the decode outputs stay asserted (min 1)
FORCE_MASK, 'h1F, XW+YW-bit mask ORed into the X/Y fields when force=1

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
cyc_start  in  1  memory-cycle start; clears the register and load flags
ta  in  1  transfer enable; gates ld_x and ld_y
ld_x  in  1  load X field and sector field from tr_data
ld_y  in  1  load Y field from tr_data
tr_data  in  AW  transfer register (AW=XW+YW+SW; bit order [S|Y|X], X in LSBs)
inc  in  1  increment X/Y address (sequential fetch)
force  in  1  extended mode; OR FORCE_MASK into X/Y
drv_en  in  1  request drive window
addr  out  AW  current address register
ax_n  out  2**XW  active-low one-hot X select
ay_n  out  2**YW  active-low one-hot Y select
as_n  out  2**SW  active-low one-hot sector select
drv_valid  out  1  high while decode outputs are asserted
wrap  out  1  one-cycle pulse when inc wraps X/Y from all-ones to zero
err  out  1  sticky error; cleared only by rst_n

Behaviour:
- One clock; reset is synchronous and active-low: rst_n=0 sampled on a clk edge resets everything.
- Reset values: addr=0, ax_n/ay_n/as_n all ones, drv_valid=0, wrap=0, err=0, state IDLE, load flags clear.
- States:
  - IDLE: no fields loaded.
  - PART: one field loaded.
  - READY: both fields loaded since the last cyc_start.
  - DRIVE: decode outputs asserted.
  - RECOVER: 1 cycle, outputs inactive.
- Loads:
  - ld_x&ta: addr X and S fields <= tr_data fields; x_flag=1.
  - ld_y&ta: addr Y field <= tr_data Y field; y_flag=1.
  - ld_x and ld_y together load both fields.
  - Any load without ta is ignored.
  - Latency: load at edge n, visible on addr after edge n.
- inc (IDLE/PART/READY only):
  - {Y,X} <= {Y,X}+1 modulo 2**(XW+YW); S is unchanged.
  - Wrap from all-ones pulses wrap for 1 cycle.
  - inc does not set the load flags.
- force: after any same-cycle load/inc, {Y,X} |= FORCE_MASK.
- Same-cycle priority: rst_n > cyc_start > load > inc > force. cyc_start suppresses load, inc and force in that cycle.
- Transitions:
  - cyc_start: addr <= 0, flags clear, state IDLE.
  - IDLE/PART -> READY when both flags are set.
  - READY & drv_en -> DRIVE.
  - drv_en in IDLE/PART: err=1, state unchanged.
- DRIVE:
  - Outputs asserted the cycle after drv_en is sampled, for exactly DRIVE_CYC cycles: ax_n[X]=0, ay_n[Y]=0, as_n[S]=0, all other bits 1, drv_valid=1.
  - Decode reflects the addr value held at DRIVE entry. addr is frozen during DRIVE.
  - ld/inc/force during DRIVE: ignored, err=1.
  - cyc_start during DRIVE (abort): outputs all ones and drv_valid=0 on the next cycle, addr cleared, state IDLE, err=1.
- After DRIVE_CYC cycles: RECOVER (outputs inactive) -> IDLE with flags clear. addr is retained for a subsequent inc.
- Decode outputs are registered; exactly one bit low per group in DRIVE, all high otherwise.
- Reset mid-DRIVE: immediate return to reset values on that edge.

Decomposition:
- Shared package: state enum (IDLE, PART, READY, DRIVE, RECOVER); field-offset constants; one-hot width helper function.
- One sub-module, onehot_dec_n (parameter W, input value, enable, active-low registered-free combinational output), instantiated three times for X, Y and sector.

Test Plan:
1. Reset then idle: ax_n=8'hFF, ay_n=8'hFF, as_n=8'hFF, addr=0, err=0.
2. ta=1, ld_x with tr_data=9'b101_000_011, then ld_y with tr_data=9'b000_110_000, then drv_en:
   - For 2 cycles: ax_n=8'hF7, ay_n=8'hBF, as_n=8'hDF, drv_valid=1.
   - RECOVER, then IDLE with all outputs high.
3. ld_x with ta=0 -> addr unchanged; later drv_en -> err=1, no drive.
4. addr={S=2,Y=7,X=7}, inc -> addr={2,0,0}, wrap=1 for exactly 1 cycle.
5. ld_x and ld_y with tr_data=0 and force=1 in the same cycle (FORCE_MASK='h1F) -> addr=9'h01F.
6. cyc_start during the first DRIVE cycle -> next cycle outputs all ones, drv_valid=0, addr=0, err=1. Also: ld_x during DRIVE -> addr frozen, err=1.

Source files
------------

// File: rtl/addr_reg_xy_decode_pkg.sv
// Shared types and helpers for the X/Y/sector address register and decoder.
//   state_t  : sequencing states of the address register
//   y_lsb    : bit offset of the Y field in the packed address [S|Y|X]
//   s_lsb    : bit offset of the sector field
//   onehot_w : one-hot width for an n-bit field (2**n)
package addr_reg_xy_decode_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PART    = 3'd1,
    READY   = 3'd2,
    DRIVE   = 3'd3,
    RECOVER = 3'd4
  } state_t;

  localparam int unsigned X_LSB = 0;

  function automatic int unsigned y_lsb(input int unsigned xw);
    return xw;
  endfunction

  function automatic int unsigned s_lsb(input int unsigned xw, input int unsigned yw);
    return xw + yw;
  endfunction

  function automatic int unsigned onehot_w(input int unsigned w);
    return 32'd1 << w;
  endfunction

endpackage

// File: rtl/addr_reg_xy_decode_onehot_dec_n.sv
// Combinational active-low one-hot decoder.
//   value    : W-bit field to decode
//   en       : when low, all outputs are inactive (high)
//   dec_n_c  : 2**W-bit active-low one-hot select (unregistered)
module onehot_dec_n
  import addr_reg_xy_decode_pkg::*;
#(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0]              value,
  input  logic                      en,
  output logic [onehot_w(W)-1:0]    dec_n_c
);

  always_comb begin
    dec_n_c = '1;
    if (en) dec_n_c[value] = 1'b0;
  end

endmodule

// File: rtl/addr_reg_xy_decode.sv
// Memory address register with X/Y/sector core-driver decode.
//   clk, rst_n : clock, synchronous active-low reset
//   cyc_start  : start of memory cycle; clears address and load flags
//   ta         : transfer enable gating ld_x / ld_y
//   ld_x, ld_y : load X+sector / Y fields from tr_data ([S|Y|X], X in LSBs)
//   inc        : increment {Y,X} (sequential fetch)
//   force_en   : extended mode, ORs FORCE_MASK into {Y,X} ("force" is a reserved word)
//   drv_en     : request a drive window
//   addr       : current address register
//   ax_n/ay_n/as_n : registered active-low one-hot selects
//   drv_valid  : decode outputs asserted
//   wrap       : one-cycle pulse when inc wraps {Y,X} to zero
//   err        : sticky protocol error, cleared only by rst_n
module addr_reg_xy_decode
  import addr_reg_xy_decode_pkg::*;
#(
  parameter int unsigned XW        = 3,
  parameter int unsigned YW        = 3,
  parameter int unsigned SW        = 3,
  parameter int unsigned DRIVE_CYC = 2,
  parameter logic [XW+YW-1:0] FORCE_MASK = 'h1F
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cyc_start,
  input  logic                       ta,
  input  logic                       ld_x,
  input  logic                       ld_y,
  input  logic [XW+YW+SW-1:0]        tr_data,
  input  logic                       inc,
  input  logic                       force_en,
  input  logic                       drv_en,
  output logic [XW+YW+SW-1:0]        addr,
  output logic [onehot_w(XW)-1:0]    ax_n,
  output logic [onehot_w(YW)-1:0]    ay_n,
  output logic [onehot_w(SW)-1:0]    as_n,
  output logic                       drv_valid,
  output logic                       wrap,
  output logic                       err
);

  localparam int unsigned XYW   = XW + YW;
  localparam int unsigned Y_LSB = y_lsb(XW);
  localparam int unsigned S_LSB = s_lsb(XW, YW);
  localparam int unsigned CW    = (DRIVE_CYC > 1) ? $clog2(DRIVE_CYC) : 1;

  state_t            state;
  logic              x_flag, y_flag;
  logic [CW-1:0]     cnt;

  logic              ld_x_ok_c, ld_y_ok_c, x_nf_c, y_nf_c, drive_go_c;
  logic [XYW-1:0]    xy_nxt_c;
  logic [SW-1:0]     s_nxt_c;
  logic              wrap_nxt_c;
  logic [onehot_w(XW)-1:0] ax_dec_c;
  logic [onehot_w(YW)-1:0] ay_dec_c;
  logic [onehot_w(SW)-1:0] as_dec_c;

  assign ld_x_ok_c  = ta & ld_x;
  assign ld_y_ok_c  = ta & ld_y;
  assign x_nf_c     = x_flag | ld_x_ok_c;
  assign y_nf_c     = y_flag | ld_y_ok_c;
  assign drive_go_c = ~cyc_start & drv_en & (state == READY);

  // Next address in the load/inc states: load beats inc, force applied last.
  always_comb begin
    xy_nxt_c   = addr[XYW-1:0];
    s_nxt_c    = addr[S_LSB +: SW];
    wrap_nxt_c = 1'b0;
    if (ld_x_ok_c) begin
      xy_nxt_c[X_LSB +: XW] = tr_data[X_LSB +: XW];
      s_nxt_c               = tr_data[S_LSB +: SW];
    end
    if (ld_y_ok_c) xy_nxt_c[Y_LSB +: YW] = tr_data[Y_LSB +: YW];
    if (!(ld_x_ok_c || ld_y_ok_c) && inc) begin
      wrap_nxt_c = &addr[XYW-1:0];
      xy_nxt_c   = addr[XYW-1:0] + XYW'(1);
    end
    if (force_en) xy_nxt_c = xy_nxt_c | FORCE_MASK;
  end

  // Decoders see the address at DRIVE entry; outputs are captured below.
  onehot_dec_n #(.W(XW)) u_dec_x (.value(addr[X_LSB +: XW]), .en(drive_go_c), .dec_n_c(ax_dec_c));
  onehot_dec_n #(.W(YW)) u_dec_y (.value(addr[Y_LSB +: YW]), .en(drive_go_c), .dec_n_c(ay_dec_c));
  onehot_dec_n #(.W(SW)) u_dec_s (.value(addr[S_LSB +: SW]), .en(drive_go_c), .dec_n_c(as_dec_c));

  // Sequencer, address register and registered decode outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      x_flag    <= 1'b0;
      y_flag    <= 1'b0;
      cnt       <= '0;
      ax_n      <= '1;
      ay_n      <= '1;
      as_n      <= '1;
      drv_valid <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (cyc_start) begin
        addr   <= '0;
        x_flag <= 1'b0;
        y_flag <= 1'b0;
        state  <= IDLE;
        if (state == DRIVE) begin
          // abort of an active drive window
          err       <= 1'b1;
          ax_n      <= '1;
          ay_n      <= '1;
          as_n      <= '1;
          drv_valid <= 1'b0;
        end
      end else begin
        case (state)
          IDLE, PART, READY: begin
            if (drive_go_c) begin
              state     <= DRIVE;
              cnt       <= '0;
              ax_n      <= ax_dec_c;
              ay_n      <= ay_dec_c;
              as_n      <= as_dec_c;
              drv_valid <= 1'b1;
            end else begin
              addr   <= {s_nxt_c, xy_nxt_c};
              wrap   <= wrap_nxt_c;
              x_flag <= x_nf_c;
              y_flag <= y_nf_c;
              if (x_nf_c && y_nf_c)      state <= READY;
              else if (x_nf_c || y_nf_c) state <= PART;
              else                       state <= IDLE;
              if (drv_en) err <= 1'b1;
            end
          end
          DRIVE: begin
            if (ld_x || ld_y || inc || force_en) err <= 1'b1;
            if (cnt == CW'(DRIVE_CYC - 1)) begin
              state     <= RECOVER;
              ax_n      <= '1;
              ay_n      <= '1;
              as_n      <= '1;
              drv_valid <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          RECOVER: begin
            state  <= IDLE;
            x_flag <= 1'b0;
            y_flag <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_addr_reg_xy_decode.sv
module tb_addr_reg_xy_decode;

  logic       clk = 1'b0;
  logic       rst_n, cyc_start, ta, ld_x, ld_y, inc, force_en, drv_en;
  logic [8:0] tr_data;
  logic [8:0] addr;
  logic [7:0] ax_n, ay_n, as_n;
  logic       drv_valid, wrap, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addr_reg_xy_decode dut (
    .clk(clk), .rst_n(rst_n), .cyc_start(cyc_start), .ta(ta),
    .ld_x(ld_x), .ld_y(ld_y), .tr_data(tr_data), .inc(inc),
    .force_en(force_en), .drv_en(drv_en), .addr(addr),
    .ax_n(ax_n), .ay_n(ay_n), .as_n(as_n),
    .drv_valid(drv_valid), .wrap(wrap), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs set before the call are sampled on this edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cyc_start = 1'b0; ta = 1'b0; ld_x = 1'b0; ld_y = 1'b0;
    inc = 1'b0; force_en = 1'b0; drv_en = 1'b0; tr_data = '0;
    #2;

    // 1: reset state
    do_reset();
    step();
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_ax", 32'(ax_n), 32'hFF);
    chk("rst_ay", 32'(ay_n), 32'hFF);
    chk("rst_as", 32'(as_n), 32'hFF);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_dv", 32'(drv_valid), 32'h0);

    // 2: X/S load, Y load, drive window
    ta = 1'b1; ld_x = 1'b1; tr_data = 9'b101_000_011;
    step();
    ld_x = 1'b0;
    chk("ldx_addr", 32'(addr), 32'h143);
    ld_y = 1'b1; tr_data = 9'b000_110_000;
    step();
    ld_y = 1'b0;
    chk("ldy_addr", 32'(addr), 32'h173);
    drv_en = 1'b1;
    step();
    drv_en = 1'b0;
    chk("drv1_ax", 32'(ax_n), 32'hF7);
    chk("drv1_ay", 32'(ay_n), 32'hBF);
    chk("drv1_as", 32'(as_n), 32'hDF);
    chk("drv1_dv", 32'(drv_valid), 32'h1);
    step();
    chk("drv2_dv", 32'(drv_valid), 32'h1);
    chk("drv2_ax", 32'(ax_n), 32'hF7);
    step();
    chk("rec_dv", 32'(drv_valid), 32'h0);
    chk("rec_ax", 32'(ax_n), 32'hFF);
    step();
    chk("idle_ay", 32'(ay_n), 32'hFF);
    chk("idle_as", 32'(as_n), 32'hFF);
    chk("idle_addr", 32'(addr), 32'h173);
    chk("idle_err", 32'(err), 32'h0);

    // 3: load without ta ignored; drv_en without both fields is an error
    ta = 1'b0; ld_x = 1'b1; tr_data = 9'h000;
    step();
    ld_x = 1'b0; ta = 1'b1;
    chk("nota_addr", 32'(addr), 32'h173);
    drv_en = 1'b1;
    step();
    drv_en = 1'b0;
    chk("early_err", 32'(err), 32'h1);
    chk("early_dv", 32'(drv_valid), 32'h0);
    step();
    chk("early_dv2", 32'(drv_valid), 32'h0);
    chk("early_ax", 32'(ax_n), 32'hFF);

    // 4: increment wrap from {2,7,7}
    do_reset();
    step();
    chk("rst2_err", 32'(err), 32'h0);
    ld_x = 1'b1; ld_y = 1'b1; tr_data = 9'b010_111_111;
    step();
    ld_x = 1'b0; ld_y = 1'b0;
    chk("ld_277", 32'(addr), 32'h0BF);
    chk("nowrap", 32'(wrap), 32'h0);
    inc = 1'b1;
    step();
    inc = 1'b0;
    chk("inc_addr", 32'(addr), 32'h080);
    chk("wrap1", 32'(wrap), 32'h1);
    step();
    chk("wrap0", 32'(wrap), 32'h0);
    chk("inc_hold", 32'(addr), 32'h080);

    // 5: cyc_start clear, then simultaneous load with force
    cyc_start = 1'b1;
    step();
    cyc_start = 1'b0;
    chk("cyc_addr", 32'(addr), 32'h0);
    ld_x = 1'b1; ld_y = 1'b1; tr_data = 9'h000; force_en = 1'b1;
    step();
    ld_x = 1'b0; ld_y = 1'b0; force_en = 1'b0;
    chk("force_addr", 32'(addr), 32'h01F);

    // 6a: abort during first drive cycle
    drv_en = 1'b1;
    step();
    drv_en = 1'b0;
    chk("f_ax", 32'(ax_n), 32'h7F);
    chk("f_ay", 32'(ay_n), 32'hF7);
    chk("f_as", 32'(as_n), 32'hFE);
    chk("f_dv", 32'(drv_valid), 32'h1);
    chk("f_err0", 32'(err), 32'h0);
    cyc_start = 1'b1;
    step();
    cyc_start = 1'b0;
    chk("abort_ax", 32'(ax_n), 32'hFF);
    chk("abort_dv", 32'(drv_valid), 32'h0);
    chk("abort_addr", 32'(addr), 32'h0);
    chk("abort_err", 32'(err), 32'h1);

    // 6b: load during drive is ignored and flagged
    do_reset();
    step();
    ld_x = 1'b1; ld_y = 1'b1; tr_data = 9'h173;
    step();
    ld_x = 1'b0; ld_y = 1'b0;
    drv_en = 1'b1;
    step();
    drv_en = 1'b0;
    chk("d_err0", 32'(err), 32'h0);
    ld_x = 1'b1; tr_data = 9'h000;
    step();
    ld_x = 1'b0;
    chk("frz_addr", 32'(addr), 32'h173);
    chk("frz_err", 32'(err), 32'h1);
    chk("frz_dv", 32'(drv_valid), 32'h1);
    chk("frz_ax", 32'(ax_n), 32'hF7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
